// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator: split, read-modify-write and extend data memory accesses
module lsu_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h10010000,
    parameter int          SPAN_BYTES = 8192
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic        in_req_wr,
    input  logic [1:0]  in_req_size,
    input  logic        in_req_sign,
    input  logic [31:0] in_req_addr,
    input  logic [31:0] in_req_data,
    output logic        out_resp_valid,
    output logic [31:0] out_resp_data,
    output logic        out_resp_err,
    output logic        out_mem_ena,
    output logic        out_mem_wena,
    output logic [1:0]  out_mem_wsel,
    output logic [1:0]  out_mem_rsel,
    output logic [31:0] out_mem_addr,
    output logic [31:0] out_mem_data,
    input  logic [31:0] in_mem_data
);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, data_q, buf0, buf1, resp_data_q;
    logic [1:0]  size_q;
    logic        sign_q, wr_q, err_q;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    logic        accept, req_err, span;
    logic [2:0]  n_in, n_q;
    logic [1:0]  off;
    logic [32:0] last_byte;
    logic [31:0] word_a;

    assign accept    = in_req_valid && out_req_ready;
    assign n_in      = size_bytes(in_req_size);
    assign last_byte = {1'b0, in_req_addr} + {30'b0, n_in} - 33'd1;
    // 33-bit compare so a request near 0xFFFFFFFF cannot wrap into the window
    assign req_err   = (in_req_size == 2'b11) || (in_req_addr < BASE_ADDR) ||
                       (last_byte > ({1'b0, BASE_ADDR} + 33'(SPAN_BYTES) - 33'd1));

    assign n_q    = size_bytes(size_q);
    assign off    = addr_q[1:0];
    assign span   = ({1'b0, off} + n_q) > 3'd4;
    assign word_a = {addr_q[31:2], 2'b00};

    // Store bytes placed across the two-word window; mask selects the request's bytes.
    logic [3:0]  byte_mask;
    logic [7:0]  mask64;
    logic [63:0] sdata64, pair;
    logic [31:0] wr_word0, wr_word1, raw, load_result;

    assign byte_mask = (n_q == 3'd1) ? 4'b0001 : (n_q == 3'd2) ? 4'b0011 : 4'b1111;
    assign mask64    = 8'({4'b0, byte_mask} << off);
    assign sdata64   = {32'b0, data_q} << {off, 3'b000};

    always_comb begin
        wr_word0 = buf0;
        wr_word1 = buf1;
        for (int b = 0; b < 4; b++) begin
            if (mask64[b])     wr_word0[8*b +: 8] = sdata64[8*b +: 8];
            if (mask64[b + 4]) wr_word1[8*b +: 8] = sdata64[32 + 8*b +: 8];
        end
    end

    // Final load word arrives on in_mem_data in the cycle that enters DONE.
    assign pair = (state == RD1) ? {in_mem_data, buf0} : {32'b0, in_mem_data};
    assign raw  = 32'(pair >> {off, 3'b000});

    always_comb begin
        load_result = raw;
        if (n_q == 3'd1)
            load_result = {{24{sign_q & raw[7]}}, raw[7:0]};
        else if (n_q == 3'd2)
            load_result = {{16{sign_q & raw[15]}}, raw[15:0]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)
                    state_nx = DONE;
                else if (in_req_wr && in_req_size == 2'b10 && in_req_addr[1:0] == 2'b00)
                    state_nx = WR0;
                else
                    state_nx = RD0;
            end
            RD0:     state_nx = wr_q ? WR0 : (span ? RD1 : DONE);
            WR0:     state_nx = span ? RD1 : DONE;
            RD1:     state_nx = wr_q ? WR1 : DONE;
            WR1:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            buf0        <= '0;
            buf1        <= '0;
            resp_data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= in_req_addr;
                data_q <= in_req_data;
                size_q <= in_req_size;
                sign_q <= in_req_sign;
                wr_q   <= in_req_wr;
                err_q  <= req_err;
            end
            if (state == RD0) buf0 <= in_mem_data;
            if (state == RD1) buf1 <= in_mem_data;
            if (state_nx == DONE && state != DONE)
                resp_data_q <= (state == IDLE || wr_q) ? 32'b0 : load_result;
        end
    end

    assign out_req_ready  = (state == IDLE) && !in_rst;
    assign out_resp_valid = (state == DONE);
    assign out_resp_err   = (state == DONE) && err_q;
    assign out_resp_data  = resp_data_q;
    assign out_mem_wsel   = 2'b01;
    assign out_mem_rsel   = 2'b01;

    always_comb begin
        out_mem_ena  = 1'b0;
        out_mem_wena = 1'b0;
        out_mem_addr = 32'b0;
        out_mem_data = 32'b0;
        case (state)
            RD0: begin
                out_mem_ena  = 1'b1;
                out_mem_addr = word_a;
            end
            WR0: begin
                out_mem_ena  = 1'b1;
                out_mem_wena = 1'b1;
                out_mem_addr = word_a;
                out_mem_data = wr_word0;
            end
            RD1: begin
                out_mem_ena  = 1'b1;
                out_mem_addr = word_a + 32'd4;
            end
            WR1: begin
                out_mem_ena  = 1'b1;
                out_mem_wena = 1'b1;
                out_mem_addr = word_a + 32'd4;
                out_mem_data = wr_word1;
            end
            default: ;
        endcase
    end

endmodule
